// File: rtl/pulse_pkg.sv
// pulse_pkg: shared types and defaults for the pulse emitter
//   emitter_state_t : burst FSM states
//   pulse_cfg_t     : latched burst configuration {width, period, count}
package pulse_pkg;
    localparam int CNT_W_DEF = 16;
    localparam int TS_W_DEF  = 32;

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW,
        DONE
    } emitter_state_t;

    typedef struct packed {
        logic [CNT_W_DEF-1:0] width;
        logic [CNT_W_DEF-1:0] period;
        logic [CNT_W_DEF-1:0] count;
    } pulse_cfg_t;
endpackage

// File: rtl/phase_timer.sv
// phase_timer: loadable down-counter timing one pulse phase
//   clk, rst_n : clock, async active-low reset
//   load       : load load_val (takes priority over en)
//   en         : count down while the phase runs
//   load_val   : phase length in cycles (>= 1)
//   tc         : high during the last cycle of the phase (count == 1)
module phase_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] load_val,
    output logic             tc
);
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (en && cnt != '0)
            cnt <= cnt - 1'b1;

    assign tc = cnt == CNT_W'(1);
endmodule

// File: rtl/pulse_emitter.sv
// pulse_emitter: programmable burst pulse transmitter for loopback latency checks
//   clk, rst_n       : clock, async active-low reset
//   start, stop      : burst start / stop-request strobes
//   cfg_width/period/count : high time, period, pulses per burst (0 = until stop)
//   pulse_out        : registered pulse output
//   busy, done       : burst in progress / one-cycle end-of-burst strobe
//   pulse_idx        : pulses started in the current burst
//   ts_value/ts_valid: rising-edge timestamp; live only with PULSE_EMITTER_TIMESTAMP_EN
module pulse_emitter
    import pulse_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int TS_W  = TS_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic [CNT_W-1:0] cfg_width,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [CNT_W-1:0] cfg_count,
    output logic             pulse_out,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pulse_idx,
    output logic [TS_W-1:0]  ts_value,
    output logic             ts_valid
);
    emitter_state_t   state, state_nx;
    pulse_cfg_t       sh;
    logic             stop_pend, accept, tc, load, last;
    logic [CNT_W-1:0] w_s, low_s, load_val;

    // sh.period holds the low-phase length P-W; P > W always, so no overflow
    assign w_s    = cfg_width == '0 ? CNT_W'(1) : cfg_width;
    assign low_s  = cfg_period > w_s ? cfg_period - w_s : CNT_W'(1);
    assign accept = state == IDLE && start;
    assign last   = (sh.count != '0 && pulse_idx == sh.count) || stop_pend || stop;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? HIGH : IDLE;
            HIGH:    state_nx = tc ? LOW : HIGH;
            LOW:     state_nx = tc ? (last ? DONE : HIGH) : LOW;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;

    assign load     = accept || (state == HIGH && tc) || (state == LOW && state_nx == HIGH);
    assign load_val = accept ? w_s : (state == HIGH ? sh.period : sh.width);

    phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .en       (state == HIGH || state == LOW),
        .load_val (load_val),
        .tc       (tc)
    );

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            sh        <= '0;
            stop_pend <= 1'b0;
            pulse_out <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pulse_idx <= '0;
        end else begin
            pulse_out <= state_nx == HIGH;
            busy      <= state_nx == HIGH || state_nx == LOW;
            done      <= state_nx == DONE;
            if (accept) begin
                sh        <= '{w_s, low_s, cfg_count};
                pulse_idx <= CNT_W'(1);
            end else if (state == LOW && state_nx == HIGH)
                pulse_idx <= pulse_idx + 1'b1;
            stop_pend <= state == IDLE ? 1'b0 : stop_pend | (stop && (state == HIGH || state == LOW));
        end

`ifdef PULSE_EMITTER_TIMESTAMP_EN
    logic [TS_W-1:0] ts_cnt;
    logic            rise;

    assign rise = state_nx == HIGH && state != HIGH;

    // ts_value is the counter value of the first cycle pulse_out reads 1
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            ts_cnt   <= '0;
            ts_value <= '0;
            ts_valid <= 1'b0;
        end else begin
            ts_cnt   <= ts_cnt + 1'b1;
            ts_valid <= rise;
            if (rise)
                ts_value <= ts_cnt + 1'b1;
        end
`else
    assign ts_value = '0;
    assign ts_valid = 1'b0;
`endif
endmodule

// File: tb/tb_pulse_emitter.sv
// tb_pulse_emitter: randomized self-checking bench against a burst-schedule model
module tb_pulse_emitter;
    import pulse_pkg::*;
    localparam int CW = CNT_W_DEF;
    localparam int TW = TS_W_DEF;

    logic          clk = 1'b0;
    logic          rst_n, start, stop;
    logic [CW-1:0] cfg_width, cfg_period, cfg_count;
    logic          pulse_out, busy, done, ts_valid;
    logic [CW-1:0] pulse_idx;
    logic [TW-1:0] ts_value;
    int            n_chk = 0;
    int            n_pass = 0;

    always #5 clk = ~clk;

    pulse_emitter #(.CNT_W(CW), .TS_W(TW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .cfg_width  (cfg_width),
        .cfg_period (cfg_period),
        .cfg_count  (cfg_count),
        .pulse_out  (pulse_out),
        .busy       (busy),
        .done       (done),
        .pulse_idx  (pulse_idx),
        .ts_value   (ts_value),
        .ts_valid   (ts_valid)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    // Model: cycle t after the start cycle lies in pulse (t-1)/P at phase (t-1)%P;
    // a burst of n pulses ends with done at t = n*P+1. A stop seen while busy
    // caps n at the pulse it fell in.
    task automatic burst(input int w, input int p, input int c, input int stop_t,
                         input int rst_t, input bit poke);
        int            ws, ps, n, t;
        longint        end_t;
        bit            ts_seen;
        logic [TW-1:0] last_ts, d;
        ws = (w == 0) ? 1 : w;
        ps = (p > ws) ? p : ws + 1;
        n  = (c == 0) ? 32'h3fff_ffff : c;
        end_t = longint'(n) * ps + 1;
        cfg_width  = CW'(w);
        cfg_period = CW'(p);
        cfg_count  = CW'(c);
        start = 1'b1;
        stop  = (stop_t == 0);
        t = 0;
        ts_seen = 1'b0;
        last_ts = '0;
        while (t <= end_t) begin
            @(posedge clk);
            #1;
            t++;
            if (t > 5000) begin
                check("timeout", t, 0);
                break;
            end
            if (t < end_t) begin
                check("pulse_out", pulse_out, ((t - 1) % ps) < ws);
                check("busy", busy, 1);
                check("done", done, 0);
                check("pulse_idx", pulse_idx, ((t - 1) / ps + 1) % 65536);
            end else begin
                check("pulse_out_end", pulse_out, 0);
                check("busy_end", busy, 0);
                check("done_end", done, t == end_t);
                check("pulse_idx_end", pulse_idx, n);
            end
`ifdef PULSE_EMITTER_TIMESTAMP_EN
            if (t < end_t && (t - 1) % ps == 0) begin
                check("ts_valid", ts_valid, 1);
                d = ts_value - last_ts;
                if (ts_seen)
                    check("ts_delta", d, ps);
                last_ts = ts_value;
                ts_seen = 1'b1;
            end else
                check("ts_valid_idle", ts_valid, 0);
`else
            check("ts_valid_off", ts_valid, 0);
            check("ts_value_off", ts_value, 0);
`endif
            if (t == rst_t) begin
                rst_n = 1'b0;
                #2;
                check("rst_pulse_out", pulse_out, 0);
                check("rst_busy", busy, 0);
                check("rst_done", done, 0);
                check("rst_pulse_idx", pulse_idx, 0);
                start = 1'b0;
                stop  = 1'b0;
                return;
            end
            start = poke && t < end_t && ($urandom_range(0, 3) == 0);
            stop  = (t == stop_t);
            if (poke) begin
                cfg_width  = CW'($urandom_range(0, 20));
                cfg_period = CW'($urandom_range(0, 30));
                cfg_count  = CW'($urandom_range(0, 9));
            end
            if (stop && t < end_t && (t - 1) / ps + 1 < n) begin
                n = (t - 1) / ps + 1;
                end_t = longint'(n) * ps + 1;
            end
        end
        start = 1'b0;
        stop  = 1'b0;
    endtask

    initial begin
        int w, p, c, st;
        rst_n = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        cfg_width  = '0;
        cfg_period = '0;
        cfg_count  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_pulse_out", pulse_out, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_pulse_idx", pulse_idx, 0);
        check("reset_ts_value", ts_value, 0);
        check("reset_ts_valid", ts_valid, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        burst(3, 10, 4, -1, -1, 1'b0);
        burst(0, 0, 2, -1, -1, 1'b0);
        burst(2, 5, 0, 32, -1, 1'b0);
        stop = 1'b1;
        @(posedge clk);
        #1;
        stop = 1'b0;
        check("idle_stop_busy", busy, 0);
        check("idle_hold_idx", pulse_idx, 7);
        burst(3, 10, 4, 0, -1, 1'b1);
        burst(3, 10, 4, -1, 12, 1'b0);
        repeat (2) begin
            @(posedge clk);
            #1;
            check("held_rst_done", done, 0);
            check("held_rst_busy", busy, 0);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        burst(3, 10, 4, -1, -1, 1'b0);
        burst(4, 8, 3, -1, -1, 1'b0);
        for (int i = 0; i < 12; i++) begin
            w = int'($urandom_range(0, 6));
            p = int'($urandom_range(0, 14));
            c = int'($urandom_range(0, 5));
            if (c == 0)
                st = int'($urandom_range(1, 80));
            else
                st = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 60)) : -1;
            burst(w, p, c, st, -1, 1'($urandom_range(0, 1)));
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/pulse_emitter.md
Name: pulse_emitter

Overview:
- Programmable test-pulse transmitter: the emitting end of the pulse-capture chain.
- Generates bursts of single-ended pulses with configurable high width, period and count.
- Output feeds an external differential output buffer, looped back into the LVDS capture/delay path for bench and in-system latency checks.
- Runs in the main clk domain.

Parameters:
- CNT_W, 16, width of the width, period and count configuration fields and their internal counters
- TS_W, 32, timestamp counter width (used only with the optional feature)

Ports:
- clk  input  1  main system clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle strobe; latches config and begins a burst when idle
- stop  input  1  one-cycle strobe; requests burst termination
- cfg_width  input  CNT_W  high time in clk cycles
- cfg_period  input  CNT_W  rising-edge-to-rising-edge period in clk cycles
- cfg_count  input  CNT_W  pulses per burst; 0 = continuous until stop
- pulse_out  output  1  registered pulse output
- busy  output  1  high from the cycle after an accepted start until the cycle done is asserted
- done  output  1  one-cycle strobe at burst end
- pulse_idx  output  CNT_W  number of pulses started in the current burst
- ts_value  output  TS_W  timestamp of last rising edge (optional feature only)
- ts_valid  output  1  one-cycle strobe with ts_value (optional feature only)

Behaviour:
- Reset (asynchronous, rst_n=0):
  - All outputs clear to 0: pulse_out, busy, done, pulse_idx, ts_value, ts_valid.
  - FSM goes to IDLE and counters clear.
  - A mid-burst reset drops pulse_out at once, with no completion strobe.
- FSM states: IDLE, HIGH, LOW, DONE.
- IDLE:
  - start=1 latches cfg_* into shadow registers (cfg_* are ignored afterwards) and moves to HIGH.
  - pulse_out rises 1 cycle after start (registered).
- Config sanitising, applied at latch time:
  - W = max(cfg_width,1).
  - P = max(cfg_period, W+1), which guarantees at least 1 low cycle.
- HIGH:
  - pulse_out=1 for exactly W cycles.
  - pulse_idx increments on HIGH entry.
  - Then go to LOW.
- LOW:
  - pulse_out=0 for exactly P-W cycles.
  - At the end of LOW, go to DONE if (cfg_count≠0 and pulse_idx==cfg_count) or a stop is pending; otherwise go to HIGH.
- DONE:
  - done=1 and busy drops in this same cycle.
  - Next cycle returns to IDLE.
  - pulse_idx holds its final value until the next accepted start, which clears it and then sets it to 1 on HIGH entry.
- stop:
  - Sets a sticky pending flag while in HIGH or LOW.
  - Pulses are never truncated; the burst ends after the current LOW phase.
  - stop in IDLE or DONE is ignored.
- start while not IDLE is ignored. start and stop in the same IDLE cycle: start is accepted and stop is discarded.
- Continuous mode (cfg_count=0): pulse_idx wraps 2^CNT_W-1 → 0 with no effect on operation.
- Counters: phase counter is CNT_W bits, counts down from the loaded value, with terminal count at 1. P-W is computed at latch time, unsigned, non-negative by construction.

Optional Feature:
- Macro: PULSE_EMITTER_TIMESTAMP_EN.
- Defined:
  - A TS_W free-running counter runs from reset.
  - On every HIGH entry, ts_value captures the counter value of the cycle pulse_out first reads 1.
  - ts_valid pulses for that cycle.
  - Used to measure capture-path delay against the loopback.
- Undefined:
  - ts_value and ts_valid ports remain but are tied to 0.
  - No counter logic is synthesised.

Decomposition:
- Shared package pulse_pkg holds:
  - emitter_state_t enum (IDLE, HIGH, LOW, DONE).
  - Default CNT_W/TS_W localparams.
  - Config struct pulse_cfg_t {width, period, count}.
- One natural sub-module, phase_timer: loadable down-counter with load value, enable and terminal-count output, instantiated once and reloaded per phase.

Test Plan:
- W=3, P=10, count=4, start at cycle 0 → pulse_out high in cycles 1-3, 11-13, 21-23, 31-33; done at cycle 41; pulse_idx=4; busy low from cycle 41.
- W=0, P=0, count=2 → sanitised to W=1, P=2: pulse_out 1,0,1,0 then done; no back-to-back high cycles.
- count=0, W=2, P=5, stop asserted mid-HIGH of pulse 7 → pulse 7 completes its 2 high cycles and 3 low cycles, then done; no pulse 8.
- start re-asserted while busy and cfg_* changed mid-burst → ignored; waveform matches the originally latched config.
- rst_n low during HIGH of pulse 2 → pulse_out, busy and pulse_idx go 0 asynchronously; no done; a fresh start after release behaves as the first scenario.
- With PULSE_EMITTER_TIMESTAMP_EN, W=4, P=8, count=3 → three ts_valid strobes with ts_value deltas exactly 8; without the macro, ts_valid stays 0.
